// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with persistent carry for chained ADC.
// Ops: ADD, SUB, AND, OR, XOR, ADC, PASS and, when ALU_MUL_EN is defined, a
// WIDTH-cycle shift-add MUL. Without ALU_MUL_EN, op 6 returns err with a zero result.
module alu_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_ADC  = 3'd5,
    OP_MUL  = 3'd6,
    OP_PASS = 3'd7
  } op_t;

  logic             carry;
  logic             drain_ok;
  logic             accept;
  logic             start_mul;

  logic [WIDTH-1:0] bb;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_d;
  logic             c_d;
  logic             v_d;
  logic             err_d;
  logic             c_upd;
  logic [3:0]       flg_d;

  assign drain_ok = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef ALU_MUL_EN
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplr;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;
  logic               last;
  logic               mul_c;

  assign in_ready  = rst_n && (state == IDLE) && drain_ok;
  assign start_mul = accept && (op_t'(op) == OP_MUL);
  assign prod      = acc + (mplr[0] ? mcand : '0);
  assign last      = (cnt == CW'(WIDTH - 1));
  assign mul_c     = |prod[2*WIDTH-1:WIDTH];
`else
  assign in_ready  = rst_n && drain_ok;
  assign start_mul = 1'b0;
`endif

  // Single-cycle datapath: result, flags and carry-update for the presented op
  always_comb begin
    bb    = b;
    cin   = 1'b0;
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    err_d = 1'b0;
    c_upd = 1'b0;
    case (op_t'(op))
      OP_SUB: begin
        bb  = ~b;
        cin = 1'b1;
      end
      OP_ADC: cin = carry;
      default: ;
    endcase
    sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cin};
    case (op_t'(op))
      OP_ADD, OP_SUB, OP_ADC: begin
        res_d = sum[WIDTH-1:0];
        c_d   = sum[WIDTH];
        v_d   = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        c_upd = 1'b1;
      end
      OP_AND:  res_d = a & b;
      OP_OR:   res_d = a | b;
      OP_XOR:  res_d = a ^ b;
      OP_PASS: res_d = a;
      // Reached only in the build without a multiplier (otherwise start_mul diverts it)
      OP_MUL:  err_d = 1'b1;
      default: ;
    endcase
    flg_d = {res_d[WIDTH-1], v_d, c_d, (res_d == '0)};
  end

  // Control, result register, carry register and shift-add multiplier state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      err       <= 1'b0;
      carry     <= 1'b0;
`ifdef ALU_MUL_EN
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplr      <= '0;
      cnt       <= '0;
`endif
    end else begin
      // A drain clears out_valid; any load below at the same edge overrides it
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (accept && !start_mul) begin
        result    <= res_d;
        flags     <= flg_d;
        err       <= err_d;
        out_valid <= 1'b1;
        if (c_upd) carry <= c_d;
      end

`ifdef ALU_MUL_EN
      case (state)
        IDLE: begin
          if (start_mul) begin
            state <= BUSY;
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, a};
            mplr  <= b;
            cnt   <= '0;
          end
        end
        BUSY: begin
          if (!last) begin
            acc   <= prod;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt + 1'b1;
          end else if (drain_ok) begin
            // Final step folds into the load so the accumulator is never written
            // while waiting for a full result register to drain.
            result    <= prod[WIDTH-1:0];
            flags     <= {prod[WIDTH-1], 1'b0, mul_c, (prod[WIDTH-1:0] == '0)};
            err       <= 1'b0;
            out_valid <= 1'b1;
            carry     <= mul_c;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH 4, 8 and 2.
module tb_alu_seq;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_ADC  = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic       iv4 = 1'b0, ir4, ov4, or4 = 1'b1, e4;
  logic [3:0] a4 = '0, b4 = '0, r4, f4;
  logic [2:0] op4 = '0;

  logic       iv8 = 1'b0, ir8, ov8, e8;
  logic [7:0] a8 = '0, b8 = '0, r8;
  logic [3:0] f8;
  logic [2:0] op8 = '0;

  logic       iv2 = 1'b0, ir2, ov2, e2;
  logic [1:0] a2 = '0, b2 = '0, r2;
  logic [3:0] f2;
  logic [2:0] op2 = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(4)) d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .op(op4),
    .out_valid(ov4), .out_ready(or4), .result(r4), .flags(f4), .err(e4)
  );

  alu_seq #(.WIDTH(8)) d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .op(op8),
    .out_valid(ov8), .out_ready(1'b1), .result(r8), .flags(f8), .err(e8)
  );

  alu_seq #(.WIDTH(2)) d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .op(op2),
    .out_valid(ov2), .out_ready(1'b1), .result(r2), .flags(f2), .err(e2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present an op to the WIDTH=4 instance and return 1ns after the accepting edge
  task automatic issue4(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
    int unsigned n;
    @(negedge clk);
    op4 = o; a4 = x; b4 = y; iv4 = 1'b1;
    n = 0;
    while (!ir4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("issue_ready", 32'(ir4), 1);
    @(posedge clk);
    #1 iv4 = 1'b0;
  endtask

  // Single-cycle op on WIDTH=4 with latency-1 result check
  task automatic op4chk(input string tag, input logic [2:0] o, input logic [3:0] x,
                        input logic [3:0] y, input logic [3:0] er, input logic [3:0] ef);
    issue4(o, x, y);
    check({tag, "_v"}, 32'(ov4), 1);
    check({tag, "_r"}, 32'(r4), 32'(er));
    check({tag, "_f"}, 32'(f4), 32'(ef));
    check({tag, "_e"}, 32'(e4), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ba [3];
    logic [3:0] bb [3];
    logic [2:0] bo [3];
    logic [3:0] br [3];
    logic [3:0] bf [3];

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_ov", 32'(ov4), 0);
    check("rst_r", 32'(r4), 0);
    check("rst_f", 32'(f4), 0);
    check("rst_e", 32'(e4), 0);
    check("rst_ir", 32'(ir4), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst_ir", 32'(ir4), 1);

    // Arithmetic and carry chaining ({N,V,C,Z})
    op4chk("add98", OP_ADD, 4'h9, 4'h8, 4'h1, 4'b0110);
    op4chk("sub35", OP_SUB, 4'h3, 4'h5, 4'hE, 4'b1000);
    op4chk("adc_c0", OP_ADC, 4'h0, 4'h0, 4'h0, 4'b0001);
    op4chk("addF1", OP_ADD, 4'hF, 4'h1, 4'h0, 4'b0011);
    op4chk("adc_c1", OP_ADC, 4'h0, 4'h0, 4'h1, 4'b0000);
    // Logic ops keep the carry register
    op4chk("addF1b", OP_ADD, 4'hF, 4'h1, 4'h0, 4'b0011);
    op4chk("or5A", OP_OR, 4'h5, 4'hA, 4'hF, 4'b1000);
    op4chk("adc_keep", OP_ADC, 4'h0, 4'h0, 4'h1, 4'b0000);
    op4chk("xor66", OP_XOR, 4'h6, 4'h6, 4'h0, 4'b0001);
    op4chk("pass7", OP_PASS, 4'h7, 4'h3, 4'h7, 4'b0000);

    // MUL 7*3 = 0x15
    issue4(OP_MUL, 4'h7, 4'h3);
`ifdef ALU_MUL_EN
    check("mul_busy_ir0", 32'(ir4), 0);
    check("mul_busy_ov0", 32'(ov4), 0);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      check("mul_busy_ir", 32'(ir4), 0);
      check("mul_busy_ov", 32'(ov4), 0);
    end
    @(posedge clk); #1;
    check("mul_ov", 32'(ov4), 1);
    check("mul_r", 32'(r4), 32'h5);
    check("mul_f", 32'(f4), 32'b0010);
    check("mul_e", 32'(e4), 0);
    check("mul_ir", 32'(ir4), 1);
    op4chk("adc_mulc", OP_ADC, 4'h0, 4'h0, 4'h1, 4'b0000);
`else
    check("mul_ov", 32'(ov4), 1);
    check("mul_r", 32'(r4), 0);
    check("mul_f", 32'(f4), 32'b0001);
    check("mul_e", 32'(e4), 1);
    op4chk("adc_mulc", OP_ADC, 4'h0, 4'h0, 4'h0, 4'b0001);
`endif

    // Backpressure: drain first, then hold the AND result
    @(posedge clk); #1;
    check("drained", 32'(ov4), 0);
    or4 = 1'b0;
    op4chk("and_CA", OP_AND, 4'hC, 4'hA, 4'h8, 4'b1000);
    @(negedge clk);
    op4 = OP_ADD; a4 = 4'h1; b4 = 4'h1; iv4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_ir", 32'(ir4), 0);
      check("bp_r", 32'(r4), 32'h8);
      check("bp_ov", 32'(ov4), 1);
      @(negedge clk);
    end
    or4 = 1'b1;
    #1 check("bp_release_ir", 32'(ir4), 1);
    @(posedge clk); #1;
    check("bp_next_ov", 32'(ov4), 1);
    check("bp_next_r", 32'(r4), 32'h2);
    check("bp_next_f", 32'(f4), 0);
    // Back-to-back: one transfer per cycle
    ba = '{4'h2, 4'h7, 4'hC};
    bb = '{4'h3, 4'h7, 4'h3};
    bo = '{OP_ADD, OP_SUB, OP_AND};
    br = '{4'h5, 4'h0, 4'h0};
    bf = '{4'b0000, 4'b0011, 4'b0001};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      op4 = bo[i]; a4 = ba[i]; b4 = bb[i];
      check("b2b_ir", 32'(ir4), 1);
      @(posedge clk); #1;
      check("b2b_ov", 32'(ov4), 1);
      check("b2b_r", 32'(r4), 32'(br[i]));
      check("b2b_f", 32'(f4), 32'(bf[i]));
    end
    @(negedge clk);
    iv4 = 1'b0;

    // Reset mid-operation: set carry, start a MUL, reset two cycles into BUSY
    op4chk("rst_pre_add", OP_ADD, 4'hF, 4'h1, 4'h0, 4'b0011);
`ifdef ALU_MUL_EN
    issue4(OP_MUL, 4'h3, 4'h3);
    @(posedge clk);
    @(posedge clk); #1;
    check("mid_mul_busy", 32'(ir4), 0);
`endif
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov", 32'(ov4), 0);
    check("mid_rst_r", 32'(r4), 0);
    check("mid_rst_f", 32'(f4), 0);
    check("mid_rst_e", 32'(e4), 0);
    check("mid_rst_ir", 32'(ir4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_ir", 32'(ir4), 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("rel_no_stale_ov", 32'(ov4), 0);
    end
    op4chk("rel_adc", OP_ADC, 4'h0, 4'h0, 4'h0, 4'b0001);

    // Width sweep
    @(negedge clk);
    op8 = OP_ADD; a8 = 8'h7F; b8 = 8'h01; iv8 = 1'b1;
    op2 = OP_PASS; a2 = 2'b10; b2 = 2'b01; iv2 = 1'b1;
    check("w8_ir", 32'(ir8), 1);
    check("w2_ir", 32'(ir2), 1);
    @(posedge clk); #1;
    iv8 = 1'b0; iv2 = 1'b0;
    check("w8_ov", 32'(ov8), 1);
    check("w8_r", 32'(r8), 32'h80);
    check("w8_f", 32'(f8), 32'b1100);
    check("w8_e", 32'(e8), 0);
    check("w2_ov", 32'(ov2), 1);
    check("w2_r", 32'(r2), 32'b10);
    check("w2_f", 32'(f2), 32'b1000);
    check("w2_e", 32'(e2), 0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
